// File: rtl/noc_output_arbiter_if.sv
// Link bundle between the per-port input FIFOs and the shared output stage.
// Latency: none (wires only).
// Backpressure: in_ready per input port, out_ready from the downstream link.
// Ports: in_valid/in_packet/in_ready (NUM_IN request side), out_valid/out_packet/out_ready (link side).
interface noc_output_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int PKT_W  = 14
);
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*PKT_W-1:0] in_packet;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [PKT_W-1:0]        out_packet;
  logic                    out_ready;

  // master: the environment (input FIFOs + link register); slave: the arbiter
  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_packet
  );
  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_packet
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin packet-locked arbiter sharing one router output link among NUM_IN inputs.
// Latency: 1 cycle arbitration, then 1 cycle input-to-out_valid; 1 flit/cycle while locked.
// Backpressure: in_ready only to the granted port, and only when the output register can take a flit.
// Ports: clk, rst (sync, active-high); bus (slave modport: per-port flit inputs, registered output);
//        grant_id (current/last grant), busy (locked), timeout_err (forced-release pulse), pkt_count.
module noc_output_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int PKT_W     = 14,
  parameter int MAX_FLITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  noc_output_arbiter_if.slave       bus,
  output logic [$clog2(NUM_IN)-1:0] grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [15:0]               pkt_count
);
  localparam int GW = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    rr_ptr, rr_nxt, grant_nxt, sel;
  logic [7:0]       flit_cnt, flit_cnt_nxt;
  logic             out_valid_q, out_valid_nxt;
  logic [PKT_W-1:0] out_packet_q, out_packet_nxt;
  logic             timeout_nxt;
  logic [15:0]      pkt_count_nxt;
  logic             req_any, can_load, acc, last_slot, force_eop, release_pkt;
  logic [PKT_W-1:0] acc_flit;
  int               sel_idx;

  // Rotating priority search: walk offsets high to low so the smallest
  // offset from rr_ptr with a request is the one left in sel.
  always_comb begin
    sel     = rr_ptr;
    req_any = 1'b0;
    sel_idx = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      sel_idx = int'(rr_ptr) + k;
      if (sel_idx >= NUM_IN) sel_idx = sel_idx - NUM_IN;
      if (bus.in_valid[sel_idx]) begin
        sel     = GW'(sel_idx);
        req_any = 1'b1;
      end
    end
  end

  // The output register can take a new flit if empty or draining this cycle.
  assign can_load  = !out_valid_q || bus.out_ready;
  assign acc_flit  = bus.in_packet[int'(grant_id)*PKT_W +: PKT_W];
  assign acc       = (state == LOCKED) && can_load && bus.in_valid[grant_id];
  assign last_slot = ({1'b0, flit_cnt} + 9'd1) == 9'(MAX_FLITS);
  assign force_eop = acc && !acc_flit[0] && last_slot;
  assign release_pkt = acc && (acc_flit[0] || last_slot);

  always_comb begin
    bus.in_ready = '0;
    if (state == LOCKED && can_load) bus.in_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    rr_nxt         = rr_ptr;
    flit_cnt_nxt   = flit_cnt;
    out_valid_nxt  = out_valid_q;
    out_packet_nxt = out_packet_q;
    timeout_nxt    = 1'b0;
    pkt_count_nxt  = pkt_count;

    if (out_valid_q && bus.out_ready) out_valid_nxt = 1'b0;
    if (acc) begin
      // A new flit overrides the drain above; the watchdog slot closes the packet.
      out_valid_nxt  = 1'b1;
      out_packet_nxt = {acc_flit[PKT_W-1:1], acc_flit[0] | last_slot};
      flit_cnt_nxt   = flit_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        if (req_any) begin
          state_nxt    = LOCKED;
          grant_nxt    = sel;
          flit_cnt_nxt = 8'd0;
        end
      end
      LOCKED: begin
        if (release_pkt) begin
          state_nxt     = IDLE;
          rr_nxt        = (grant_id == GW'(NUM_IN - 1)) ? '0 : grant_id + GW'(1);
          pkt_count_nxt = pkt_count + 16'd1;
          timeout_nxt   = force_eop;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_id     <= '0;
      rr_ptr       <= '0;
      flit_cnt     <= 8'd0;
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      timeout_err  <= 1'b0;
      pkt_count    <= 16'd0;
    end else begin
      state        <= state_nxt;
      grant_id     <= grant_nxt;
      rr_ptr       <= rr_nxt;
      flit_cnt     <= flit_cnt_nxt;
      out_valid_q  <= out_valid_nxt;
      out_packet_q <= out_packet_nxt;
      timeout_err  <= timeout_nxt;
      pkt_count    <= pkt_count_nxt;
    end
  end

  assign busy           = (state == LOCKED);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_packet = out_packet_q;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter (NUM_IN=4, PKT_W=14, MAX_FLITS=4).
// Latency: n/a. Backpressure: driven by table rows, fixed patterns or $urandom.
// Ports: instantiates the link interface plus clk/rst and the status outputs.
module tb_noc_output_arbiter;
  localparam int NI   = 4;
  localparam int PW   = 14;
  localparam int MAXF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [15:0] pkt_count;

  noc_output_arbiter_if #(.NUM_IN(NI), .PKT_W(PW)) bus ();

  noc_output_arbiter #(.NUM_IN(NI), .PKT_W(PW), .MAX_FLITS(MAXF)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Packet-level reference state
  logic [PW-1:0] inq[NI][$];
  logic [PW-1:0] expq[$];
  logic [PW-1:0] exp_all[$];
  int            acc_cyc[$];
  int            m_rr = 0;
  int            m_pkts = 0;
  int            m_forced = 0;
  bit            m_stuck = 0;

  typedef struct {
    logic [3:0]    iv;
    logic [PW-1:0] pkt;
    logic          ordy;
    logic          ov;
    logic [PW-1:0] op;
    logic [1:0]    gid;
    logic          bsy;
    logic [3:0]    ir;
    logic          to;
    logic [15:0]   cnt;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [1:0] d, input logic [1:0] t,
                                       input logic [7:0] pl, input logic e);
    return {1'b0, d, t, pl, e};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
    m_pkts = 0;
    for (int i = 0; i < NI; i++) inq[i].delete();
  endtask

  // Packet-level model: every port with pending flits keeps requesting, so the
  // full output stream follows from round-robin over non-empty queues, each
  // packet cut at its eop or at MAXF flits (the cut flit gets eop set).
  task automatic build_expected();
    logic [PW-1:0] q[NI][$];
    logic [PW-1:0] f;
    int p, n;
    bit found;
    for (int i = 0; i < NI; i++) q[i] = inq[i];
    expq.delete();
    m_forced = 0;
    m_stuck = 0;
    while (!m_stuck) begin
      found = 0;
      p = 0;
      for (int k = 0; k < NI; k++)
        if (!found && q[(m_rr + k) % NI].size() > 0) begin
          p = (m_rr + k) % NI;
          found = 1;
        end
      if (!found) break;
      n = 0;
      while (1) begin
        f = q[p].pop_front();
        n++;
        if (f[0] || n == MAXF) begin
          if (!f[0]) m_forced++;
          f[0] = 1'b1;
          expq.push_back(f);
          m_pkts++;
          m_rr = (p + 1) % NI;
          break;
        end
        expq.push_back(f);
        if (q[p].size() == 0) begin
          m_stuck = 1;
          break;
        end
      end
    end
    exp_all = expq;
  endtask

  // mode 0: out_ready=1, 1: random, 2: pat[cycle]. gapchk checks accept spacing (mode 0 only).
  task automatic run_stream(input int mode, input logic [63:0] pat, input int budget, input bit gapchk);
    int cyc_n = 0;
    int to_seen = 0;
    bit hold_prev = 0;
    logic [PW-1:0] prev_op = '0;
    logic [3:0] acc;
    acc_cyc.delete();
    while (expq.size() > 0 && cyc_n < budget) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        bus.in_valid[i] = (inq[i].size() > 0);
        bus.in_packet[i*PW +: PW] = (inq[i].size() > 0) ? inq[i][0] : '0;
      end
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : pat[cyc_n % 64];
      #1;
      if (hold_prev) chk("bp_hold_packet", bus.out_packet, prev_op);
      hold_prev = 0;
      if (timeout_err) to_seen++;
      if (bus.out_valid && !bus.out_ready) begin
        chk("bp_in_ready", bus.in_ready, 0);
        hold_prev = 1;
        prev_op = bus.out_packet;
      end
      if (bus.out_valid && bus.out_ready) chk("out_flit", bus.out_packet, expq.pop_front());
      acc = bus.in_valid & bus.in_ready;
      @(posedge clk);
      for (int i = 0; i < NI; i++)
        if (acc[i]) begin
          void'(inq[i].pop_front());
          acc_cyc.push_back(cyc_n);
        end
      cyc_n++;
    end
    if (expq.size() > 0) chk("stream_budget_left", expq.size(), 0);
    @(negedge clk);
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("pkt_count", pkt_count, 16'(m_pkts));
    chk("timeout_pulses", to_seen, m_forced);
    chk("accept_count", acc_cyc.size(), exp_all.size());
    if (gapchk)
      for (int j = 1; j < acc_cyc.size() && j < exp_all.size(); j++)
        chk("accept_gap", acc_cyc[j] - acc_cyc[j-1], exp_all[j-1][0] ? 2 : 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] fa, fb, fc;
    int npk, len;

    // Single request on port 2: payloads 0x11,0x22,0x33, eop on the third.
    tbl[0] = '{4'b0100, 14'h022, 1'b1, 1'b0, 14'h000, 2'd0, 1'b0, 4'b0000, 1'b0, 16'd0};
    tbl[1] = '{4'b0100, 14'h022, 1'b1, 1'b0, 14'h000, 2'd2, 1'b1, 4'b0100, 1'b0, 16'd0};
    tbl[2] = '{4'b0100, 14'h044, 1'b1, 1'b1, 14'h022, 2'd2, 1'b1, 4'b0100, 1'b0, 16'd0};
    tbl[3] = '{4'b0100, 14'h067, 1'b1, 1'b1, 14'h044, 2'd2, 1'b1, 4'b0100, 1'b0, 16'd0};
    tbl[4] = '{4'b0000, 14'h000, 1'b1, 1'b1, 14'h067, 2'd2, 1'b0, 4'b0000, 1'b0, 16'd1};
    tbl[5] = '{4'b0000, 14'h000, 1'b1, 1'b0, 14'h067, 2'd2, 1'b0, 4'b0000, 1'b0, 16'd1};

    bus.in_valid = '0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    do_reset();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_packet", bus.out_packet, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);

    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      bus.in_valid = tbl[r].iv;
      bus.in_packet = {NI{tbl[r].pkt}};
      bus.out_ready = tbl[r].ordy;
      #1;
      chk($sformatf("tbl%0d_out_valid", r), bus.out_valid, tbl[r].ov);
      chk($sformatf("tbl%0d_out_packet", r), bus.out_packet, tbl[r].op);
      chk($sformatf("tbl%0d_grant_id", r), grant_id, tbl[r].gid);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      chk($sformatf("tbl%0d_in_ready", r), bus.in_ready, tbl[r].ir);
      chk($sformatf("tbl%0d_timeout", r), timeout_err, tbl[r].to);
      chk($sformatf("tbl%0d_pkt_count", r), pkt_count, tbl[r].cnt);
    end

    // Fairness: all ports hold 2-flit packets, port 0 has two -> grants 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NI; i++) begin
      inq[i].push_back(mk(2'(i), 2'd1, 8'(8'h10 + i), 1'b0));
      inq[i].push_back(mk(2'(i), 2'd1, 8'(8'h20 + i), 1'b1));
    end
    inq[0].push_back(mk(2'd0, 2'd2, 8'h30, 1'b0));
    inq[0].push_back(mk(2'd0, 2'd2, 8'h40, 1'b1));
    build_expected();
    run_stream(0, '1, 200, 1);

    // Backpressure: out_ready low for cycles 3..5 of a 4-flit packet on port 3.
    do_reset();
    for (int k = 0; k < 4; k++) inq[3].push_back(mk(2'd3, 2'd0, 8'(8'hA0 + k), k == 3));
    build_expected();
    run_stream(2, 64'hFFFF_FFFF_FFFF_FFC7, 200, 0);

    // Watchdog: port 1 sends 6 flits with no eop; flit 4 is cut, flits 5,6 start a new packet.
    do_reset();
    for (int k = 0; k < 6; k++) inq[1].push_back(mk(2'd1, 2'd3, 8'(8'h50 + k), 1'b0));
    build_expected();
    run_stream(0, '1, 200, 1);
    chk("wd_still_locked", busy, 1);
    chk("wd_grant", grant_id, 1);

    // Stall: port 0 granted, drops in_valid for 5 cycles while port 3 requests.
    do_reset();
    fa = mk(2'd1, 2'd2, 8'h5A, 1'b0);
    fb = mk(2'd1, 2'd2, 8'hA5, 1'b1);
    fc = mk(2'd2, 2'd1, 8'h3C, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk); bus.in_valid = 4'b0001; bus.in_packet = {NI{fa}}; #1;
    chk("stall_idle_busy", busy, 0);
    @(negedge clk); #1;
    chk("stall_grant0", grant_id, 0);
    chk("stall_ready0", bus.in_ready, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); bus.in_valid = 4'b1000; #1;
      chk("stall_grant_held", grant_id, 0);
      chk("stall_port3_ready", bus.in_ready[3], 0);
    end
    @(negedge clk); bus.in_valid = 4'b1001; bus.in_packet = {NI{fb}}; #1;
    chk("stall_resume_ready", bus.in_ready, 4'b0001);
    @(negedge clk); bus.in_valid = 4'b1000; #1;
    chk("stall_port0_eop_out", bus.out_packet, fb);
    chk("stall_pkt_count", pkt_count, 1);
    @(negedge clk); bus.in_packet = {NI{fc}}; #1;
    chk("stall_grant3", grant_id, 3);
    chk("stall_busy3", busy, 1);
    // Reset mid-packet with a flit held in the output register.
    @(negedge clk); bus.out_ready = 1'b0; bus.in_valid = '0; rst = 1'b1; #1;
    chk("midrst_pending", bus.out_valid, 1);
    @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1; #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    chk("midrst_grant", grant_id, 0);
    chk("midrst_timeout", timeout_err, 0);
    bus.in_valid = 4'b1001; bus.in_packet = {NI{fb}};
    @(negedge clk); #1;
    chk("midrst_rr_ptr0", grant_id, 0);
    @(negedge clk); bus.in_valid = '0; #1;
    chk("midrst_eop_out", bus.out_packet, fb);
    chk("midrst_count1", pkt_count, 1);

    // Randomized traffic against the packet-level model.
    do_reset();
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < NI; i++) begin
        npk = $urandom_range(0, 3);
        for (int pk = 0; pk < npk; pk++) begin
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++)
            inq[i].push_back(mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                                8'($urandom_range(0, 255)), k == len - 1));
        end
      end
      build_expected();
      run_stream(1, '1, 4000, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
